mod_fold_reduce: RTL

Parametrised sequential modular reducer for a constant modulus M = 2^K − C, using iterative folding plus one final conditional subtract. It generalises the fixed 16-bit, mod-179 reducer in three ways: configurable input width and modulus, valid/ready handshakes on both sides, and a fold-count output. It sits in the coprocessor datapath between the operand register file and the result FIFO.

---
 rtl/mod_fold_pkg.sv | 27 ++
 rtl/mod_fold_step.sv | 38 +++
 rtl/mod_fold_reduce.sv | 99 +++++++++
 3 files changed

// File: rtl/mod_fold_pkg.sv
// Shared definitions for the constant-modulus fold reducer.
//   state_t        : controller states
//   mod_fold_m     : modulus M = 2^K - C
//   mod_fold_legal : parameter legality check used at elaboration
package mod_fold_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int mod_fold_m(input int k, input int c);
    return (1 << k) - c;
  endfunction

  // C must leave M above 2^(K-1) so that one final subtract suffices,
  // and the operand must be wider than a single fold chunk.
  function automatic bit mod_fold_legal(input int xw, input int k, input int c);
    if (k < 2)                                     return 1'b0;
    if (xw <= k)                                   return 1'b0;
    if (c <= 0)                                    return 1'b0;
    if (longint'(c) >= (longint'(1) << (k - 1)))   return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/mod_fold_step.sv
// Combinational datapath of the fold reducer.
//   r       : accumulator, XW+1 bits
//   r_next  : r[K-1:0] + r[XW:K]*C
//   hi_zero : r[XW:K] == 0, i.e. r < 2^K and folding is finished
//   z_final : r reduced into 0..M-1 by one conditional subtract of M
//             (only meaningful when hi_zero is set)
module mod_fold_step
  import mod_fold_pkg::*;
#(
  parameter int XW = 32,
  parameter int K  = 8,
  parameter int C  = 77
) (
  input  logic [XW:0]  r,
  output logic [XW:0]  r_next,
  output logic         hi_zero,
  output logic [K-1:0] z_final
);

  localparam int            M   = mod_fold_m(K, C);
  localparam logic [XW:0]   C_W = (XW + 1)'(C);
  localparam logic [K-1:0]  M_K = K'(M);

  logic [XW:0]  w_hi;
  logic [XW:0]  w_lo_ext;
  logic [K-1:0] w_lo;

  assign w_lo     = r[K-1:0];
  assign w_hi     = {{K{1'b0}}, r[XW:K]};
  assign w_lo_ext = {{(XW + 1 - K){1'b0}}, w_lo};

  // With C < 2^(K-1) the product stays within XW bits, so the sum
  // cannot overflow the XW+1 bit accumulator.
  assign r_next  = w_hi * C_W + w_lo_ext;
  assign hi_zero = (r[XW:K] == '0);
  assign z_final = (w_lo >= M_K) ? (w_lo - M_K) : w_lo;

endmodule

// File: rtl/mod_fold_reduce.sv
// Sequential reducer z = x mod (2^K - C) by iterative folding.
//   clk, reset           : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake, x sampled on accept edge
//   x                    : unsigned operand, XW bits
//   out_valid / out_ready: result handshake, result held until taken
//   z                    : x mod M
//   nfold                : fold steps used, saturating at 2^CW-1
module mod_fold_reduce
  import mod_fold_pkg::*;
#(
  parameter int XW = 32,
  parameter int K  = 8,
  parameter int C  = 77,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [K-1:0]  z,
  output logic [CW-1:0] nfold
);

  generate
    if (!mod_fold_legal(XW, K, C)) begin : g_bad_params
      $error("mod_fold_reduce: illegal parameters XW=%0d K=%0d C=%0d", XW, K, C);
    end
  endgenerate

  state_t        r_state;
  state_t        w_state_next;
  logic [XW:0]   r_acc;
  logic [K-1:0]  r_z;
  logic [CW-1:0] r_nfold;

  logic          w_accept;
  logic [XW:0]   w_r_next;
  logic          w_hi_zero;
  logic [K-1:0]  w_z_final;

  mod_fold_step #(
    .XW (XW),
    .K  (K),
    .C  (C)
  ) u_step (
    .r       (r_acc),
    .r_next  (w_r_next),
    .hi_zero (w_hi_zero),
    .z_final (w_z_final)
  );

  // Accepting in DONE while the result is taken keeps back-to-back
  // operation free of an idle bubble.
  assign in_ready  = !reset && ((r_state == IDLE) || ((r_state == DONE) && out_ready));
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == DONE);
  assign z         = r_z;
  assign nfold     = r_nfold;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_next = FOLD;
      FOLD: if (w_hi_zero) w_state_next = DONE;
      DONE: if (out_ready) w_state_next = w_accept ? FOLD : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc   <= '0;
      r_z     <= '0;
      r_nfold <= '0;
    end else if (w_accept) begin
      r_acc   <= {1'b0, x};
      r_nfold <= '0;
    end else if (r_state == FOLD) begin
      if (!w_hi_zero) begin
        r_acc <= w_r_next;
        if (r_nfold != '1) r_nfold <= r_nfold + 1'b1;
      end else begin
        r_z <= w_z_final;
      end
    end
  end

endmodule
